uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial receive stage directly downstream of the existing 8-bit UART transmitter.
- Recovers 8N1 frames from the tx_data line: 1 start bit (0), DATA_SIZE data bits LSB first, 1 stop bit (1).
- Runs on an oversampling clock (OVERSAMPLE × bit rate) and samples each bit mid-cell.
- Presents each byte on a held parallel output with a valid/ack handshake, and flags framing and overrun errors.

Parameters:
- DATA_SIZE, 8, data bits per frame.
- OVERSAMPLE, 16, bclk cycles per serial bit; must be even and ≥4.

Ports:
- bclk  input  1  oversampling clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_in  input  1  serial line (connects to transmitter tx_data); idle high.
- rx_ack  input  1  consumer has taken rx_data; clears rx_valid.
- rx_data  output  DATA_SIZE  last good received byte.
- rx_valid  output  1  rx_data holds an unconsumed byte (level).
- rx_busy  output  1  frame reception in progress (state ≠ IDLE).
- rx_ferr  output  1  one-cycle pulse: stop bit sampled 0.
- rx_ovr  output  1  sticky: a byte completed while rx_valid=1 without ack; cleared only by rst.

Behaviour:
- Reset (sync, rst=1 at edge):
  - State goes to IDLE; counters go to 0.
  - Both synchroniser flops go to 1.
  - rx_data=0, rx_valid=0, rx_busy=0, rx_ferr=0, rx_ovr=0.
  - Any frame in progress is discarded.
- Synchroniser: rx_in passes through 2 flops; the result is rx_s. All decisions use rx_s only.
- Counters:
  - sample counter, width clog2(OVERSAMPLE).
  - bit index, 0..DATA_SIZE-1.
  - shift register, DATA_SIZE bits; shifts right and inserts the sampled bit at the MSB, so the byte is LSB first.
- States:
  - IDLE: if rx_s==0, go to START and set cnt=0.
  - START: cnt increments each cycle. At cnt==OVERSAMPLE/2-1:
    - if rx_s==0, go to DATA with cnt=0 and idx=0;
    - else go to IDLE (glitch rejected; no flags).
  - DATA: cnt increments. At cnt==OVERSAMPLE-1, shift in rx_s and set cnt=0. If idx==DATA_SIZE-1, go to STOP; else idx++.
  - STOP: at cnt==OVERSAMPLE-1, sample rx_s:
    - if 1: load rx_data with the shift register, set rx_valid=1, go to IDLE;
    - if 0: pulse rx_ferr for 1 cycle, leave rx_data/rx_valid unchanged, go to BREAK.
  - BREAK: stay until rx_s==1, then go to IDLE. This prevents a stuck-low line from re-triggering.
- Latency (OVERSAMPLE=16, DATA_SIZE=8):
  - Edge E0 is the first edge at which rx_in is sampled low.
  - START is entered at E2.
  - Data bit k is sampled at E2 + 8 + 16(k+1).
  - The stop bit is sampled at E154. rx_valid/rx_data update at that edge.
  - General form: 2 + OVERSAMPLE/2 + (DATA_SIZE+1)·OVERSAMPLE.
- Handshake:
  - rx_ack=1 at an edge with rx_valid=1 clears rx_valid next cycle.
  - rx_ack while rx_valid=0 is ignored.
- Simultaneous events:
  - Good stop and rx_ack on the same edge: load the new byte, rx_valid stays 1, no overrun.
  - Good stop while rx_valid=1 and no rx_ack: overwrite rx_data, keep rx_valid=1, set rx_ovr=1.
- A new start bit may be detected on the cycle after STOP→IDLE; back-to-back frames are supported.
- rx_busy = (state ≠ IDLE), registered with the state.

Test Plan:
- Single frame 0xA5 (16 cycles/bit, LSB first), rx_ack held 0 → rx_valid=1 at 154 cycles after E0, rx_data=0xA5, rx_busy low same cycle, rx_ferr and rx_ovr stay 0.
- Glitch: rx_in low for 4 cycles then high → START entered, returns to IDLE at E10, rx_valid stays 0, no flags.
- Frame 0x3C with stop bit forced 0 for 32 cycles → rx_ferr pulses exactly 1 cycle, rx_data keeps its previous value, BREAK held until line high, then next frame 0x81 received correctly.
- Back-to-back 0x01, 0xFE with no idle gap; ack each byte within 10 cycles of rx_valid → both bytes received in order, rx_ovr=0.
- Two frames 0x55, 0xAA without ack → rx_data=0xAA, rx_valid=1, rx_ovr=1. Repeat with rx_ack asserted exactly on the second stop-sample edge → rx_ovr stays 0.
- rst asserted for 1 cycle in mid-DATA (bit 4 of 0xF0) → all outputs 0 next cycle. Remaining line activity is treated as a new frame only on the next falling edge. A following clean frame 0x0F is received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 serial receiver running on an oversampling clock: it samples each bit mid-cell
// and hands out a held byte through a valid/ack handshake, with framing and overrun flags.
module uart_receiver #(
  parameter int DATA_SIZE  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 bclk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic                 rx_ack,
  output logic [DATA_SIZE-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 rx_ferr,
  output logic                 rx_ovr
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_SIZE-1:0] shift_q, shift_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 rx_s;

  assign rx_s = sync2_q;

  always_comb begin
    sync1_d = rx_in;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = ovr_q;

    if (rx_ack && valid_q) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_SIZE-1:1]};
          if (idx_q == IDX_LAST) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            // An ack on this same edge frees the slot, so only an unacked byte overruns
            if (valid_q && !rx_ack) begin
              ovr_d = 1'b1;
            end
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge bclk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data  = data_q;
  assign rx_valid = valid_q;
  assign rx_busy  = busy_q;
  assign rx_ferr  = ferr_q;
  assign rx_ovr   = ovr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: a directed frame table with fixed expectations, then random
// frames checked against a frame-level model of the handshake and error flags.
module tb_uart_receiver;

  localparam int OS        = 16;
  localparam int DS        = 8;
  localparam int FRAME_LAT = 2 + OS / 2 + (DS + 1) * OS;

  logic       bclk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       rx_ferr;
  logic       rx_ovr;

  uart_receiver #(.DATA_SIZE(DS), .OVERSAMPLE(OS)) dut (
    .bclk     (bclk),
    .rst      (rst),
    .rx_in    (rx_in),
    .rx_ack   (rx_ack),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_busy  (rx_busy),
    .rx_ferr  (rx_ferr),
    .rx_ovr   (rx_ovr)
  );

  always #5 bclk = ~bclk;

  int n_vec  = 0;
  int n_miss = 0;

  // Index of the most recent rising edge, so frame events can be timed against E0
  int edge_cnt = 0;
  always @(posedge bclk) edge_cnt <= edge_cnt + 1;

  // Observe the outputs mid-cycle and note when rx_valid rises and rx_ferr pulses
  int valid_rise_edge = -1;
  int ferr_edge       = -1;
  int ferr_cnt        = 0;
  bit valid_prev      = 1'b0;
  bit busy_at_rise    = 1'b0;
  initial begin
    forever begin
      @(negedge bclk);
      if (rx_valid && !valid_prev) begin
        valid_rise_edge = edge_cnt;
        busy_at_rise    = rx_busy;
      end
      if (rx_ferr) begin
        ferr_cnt++;
        ferr_edge = edge_cnt;
      end
      valid_prev = rx_valid;
    end
  end

  logic [7:0] m_data;
  bit         m_valid;
  bit         m_ovr;
  int         m_ferr;

  typedef struct {
    logic [7:0] b;
    bit         stop_ok;
    bit         ack_first;
    bit         ack_at_stop;
    int         rst_at;
    logic [7:0] exp_data;
    bit         exp_valid;
    bit         exp_ovr;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge bclk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one whole frame bit by bit; ack_first acks the held byte at E0, ack_at_stop acks
  // on the stop-sample edge, rst_at pulses reset at that frame cycle (negative for none)
  task automatic applyStimulus(input logic [7:0] b, input bit stop_ok, input bit ack_first,
                               input bit ack_at_stop, input int rst_at, input int gap);
    logic [9:0] fr;
    logic [3:0] bi;
    int         e0;
    bit         was_valid;
    fr = {stop_ok, b, 1'b0};
    e0 = edge_cnt + 1;
    if (ack_first && m_valid) m_valid = 1'b0;
    was_valid = m_valid;
    for (int c = 0; c < 10 * OS; c++) begin
      bi     = 4'(c / OS);
      rx_in  = fr[bi];
      rx_ack = (ack_first && c == 0) || (ack_at_stop && c == FRAME_LAT);
      rst    = (c == rst_at);
      tick();
      if (c == rst_at) begin
        rst = 1'b0;
        checkOutput("rst_data",  32'(rx_data),  32'h0);
        checkOutput("rst_valid", 32'(rx_valid), 32'h0);
        checkOutput("rst_busy",  32'(rx_busy),  32'h0);
        checkOutput("rst_ferr",  32'(rx_ferr),  32'h0);
        checkOutput("rst_ovr",   32'(rx_ovr),   32'h0);
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
    end
    rx_ack = 1'b0;
    if (!stop_ok) begin
      rx_in = 1'b0;
      repeat (OS) tick();
      rx_in = 1'b1;
      repeat (OS) tick();
    end
    rx_in = 1'b1;
    repeat (gap) tick();

    if (rst_at < 0) begin
      if (stop_ok) begin
        if (was_valid && !ack_at_stop) m_ovr = 1'b1;
        m_data  = b;
        m_valid = 1'b1;
        if (!was_valid) begin
          checkOutput("valid_latency", 32'(valid_rise_edge - e0), 32'(FRAME_LAT));
          checkOutput("busy_at_valid", 32'(busy_at_rise), 32'h0);
        end
      end else begin
        if (ack_at_stop && was_valid) m_valid = 1'b0;
        m_ferr++;
        checkOutput("ferr_latency", 32'(ferr_edge - e0), 32'(FRAME_LAT));
      end
    end
  endtask

  initial begin
    int e0;
    rst    = 1'b1;
    rx_in  = 1'b1;
    rx_ack = 1'b0;
    m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checkOutput("reset_data",  32'(rx_data),  32'h0);
    checkOutput("reset_valid", 32'(rx_valid), 32'h0);
    checkOutput("reset_busy",  32'(rx_busy),  32'h0);
    checkOutput("reset_ferr",  32'(rx_ferr),  32'h0);
    checkOutput("reset_ovr",   32'(rx_ovr),   32'h0);

    // Short low glitch: START entered at E2, rejected at E10
    e0    = edge_cnt + 1;
    rx_in = 1'b0;
    repeat (3) tick();
    checkOutput("glitch_busy_e2", 32'(rx_busy), 32'h1);
    tick();
    rx_in = 1'b1;
    repeat (6) tick();
    checkOutput("glitch_busy_e9", 32'(rx_busy), 32'h1);
    tick();
    checkOutput("glitch_edge", 32'(edge_cnt - e0), 32'd10);
    checkOutput("glitch_busy_e10", 32'(rx_busy), 32'h0);
    repeat (4) tick();
    checkOutput("glitch_valid", 32'(rx_valid), 32'h0);
    checkOutput("glitch_ferr",  32'(ferr_cnt), 32'h0);

    vecs[0]  = '{8'hA5, 1'b1, 1'b0, 1'b0, -1, 8'hA5, 1'b1, 1'b0, 0};
    vecs[1]  = '{8'h3C, 1'b0, 1'b1, 1'b0, -1, 8'hA5, 1'b0, 1'b0, 1};
    vecs[2]  = '{8'h81, 1'b1, 1'b0, 1'b0, -1, 8'h81, 1'b1, 1'b0, 1};
    vecs[3]  = '{8'h01, 1'b1, 1'b1, 1'b0, -1, 8'h01, 1'b1, 1'b0, 1};
    vecs[4]  = '{8'hFE, 1'b1, 1'b1, 1'b0, -1, 8'hFE, 1'b1, 1'b0, 1};
    vecs[5]  = '{8'h55, 1'b1, 1'b1, 1'b0, -1, 8'h55, 1'b1, 1'b0, 1};
    vecs[6]  = '{8'hAA, 1'b1, 1'b0, 1'b0, -1, 8'hAA, 1'b1, 1'b1, 1};
    vecs[7]  = '{8'hF0, 1'b1, 1'b0, 1'b0, 88, 8'h00, 1'b0, 1'b0, 1};
    vecs[8]  = '{8'h0F, 1'b1, 1'b0, 1'b0, -1, 8'h0F, 1'b1, 1'b0, 1};
    vecs[9]  = '{8'h55, 1'b1, 1'b1, 1'b0, -1, 8'h55, 1'b1, 1'b0, 1};
    vecs[10] = '{8'hAA, 1'b1, 1'b0, 1'b1, -1, 8'hAA, 1'b1, 1'b0, 1};
    vecs[11] = '{8'h3C, 1'b1, 1'b1, 1'b0, -1, 8'h3C, 1'b1, 1'b0, 1};

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].b, vecs[i].stop_ok, vecs[i].ack_first, vecs[i].ack_at_stop,
                    vecs[i].rst_at, 0);
      checkOutput($sformatf("vec%0d_data", i),  32'(rx_data),  32'(vecs[i].exp_data));
      checkOutput($sformatf("vec%0d_valid", i), 32'(rx_valid), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("vec%0d_ovr", i),   32'(rx_ovr),   32'(vecs[i].exp_ovr));
      checkOutput($sformatf("vec%0d_ferr", i),  32'(ferr_cnt), 32'(vecs[i].exp_ferr));
      checkOutput($sformatf("vec%0d_busy", i),  32'(rx_busy),  32'h0);
    end

    for (int i = 0; i < 12; i++) begin
      logic [7:0] rb;
      rb = 8'($urandom_range(0, 255));
      applyStimulus(rb, $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3) == 0, -1, int'($urandom_range(0, 20)));
      checkOutput($sformatf("rnd%0d_data", i),  32'(rx_data),  32'(m_data));
      checkOutput($sformatf("rnd%0d_valid", i), 32'(rx_valid), 32'(m_valid));
      checkOutput($sformatf("rnd%0d_ovr", i),   32'(rx_ovr),   32'(m_ovr));
      checkOutput($sformatf("rnd%0d_ferr", i),  32'(ferr_cnt), 32'(m_ferr));
      checkOutput($sformatf("rnd%0d_busy", i),  32'(rx_busy),  32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
